cov_matrix_loader: RTL and testbench
====================================

# cov_matrix_loader

Downstream stage of the covariance unit. Once the covariance Controller-BRAM interface signals that the matrix is fully written, this block reads the NxN covariance matrix out of BRAM, rebuilds it in a register array, and tracks the largest-magnitude off-diagonal element (pivot) during the read. It then presents matrix plus pivot to the Jacobi eigen-solver through a valid/ready handshake.

## Interface
- MATRIX_SIZE, 4: N, matrix dimension; N >= 2
- ELEM_WIDTH, 32: element width, signed two's complement; matches the 32-bit BRAM word
- BRAM_LATENCY, 1: BRAM read latency in cycles; legal values 1..3
- ADDR_WIDTH, $clog2(MATRIX_SIZE*MATRIX_SIZE): BRAM address width
- Reset convention: one clock; reset is synchronous and active-high
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  load request; driven by the covariance unit's done_writing; sampled only in IDLE
- bram_en  output  1  BRAM read enable
- bram_addr  output  ADDR_WIDTH  read address, row-major: i*N + j
- bram_dout  input  ELEM_WIDTH  read data, valid BRAM_LATENCY cycles after the matching bram_en
- matrix_out  output  ELEM_WIDTH x N*N  reconstructed matrix, row-major
- matrix_valid  output  1  matrix_out and pivot_* are stable and complete
- matrix_ready  input  1  Jacobi unit accepts the matrix
- pivot_p  output  $clog2(N)  pivot row index (p < q)
- pivot_q  output  $clog2(N)  pivot column index
- pivot_mag  output  ELEM_WIDTH  |a[p][q]|, unsigned
- busy  output  1  high in READ and DRAIN

## Operation
- FSM states: IDLE, READ, DRAIN, VALID.
- IDLE -> READ when start=1. On that edge the block:
  - clears pivot_mag to 0
  - sets pivot_p=0 and pivot_q=1
  - resets the address counter
- READ: issues one address per cycle with bram_en=1, in row-major order. Goes to DRAIN after the last address.
- DRAIN: bram_en=0 for BRAM_LATENCY cycles while the read pipeline empties. Then goes to VALID.
- VALID: matrix_valid=1, all outputs held. Goes to IDLE on the cycle when matrix_ready=1.
- start is ignored outside IDLE. If start is still high on return to IDLE, a new load begins.
- Read pipeline: a shift register of BRAM_LATENCY stages, each stage holding a valid bit plus (i,j). Returned data is written to matrix_out[i*N+j].
- Pivot update: applies to captured elements with j > i only.
  - Magnitude is computed as |x| in ELEM_WIDTH-bit unsigned arithmetic. The most negative value -2^(ELEM_WIDTH-1) maps to 2^(ELEM_WIDTH-1) with no saturation.
  - The pivot is updated only if the magnitude is strictly greater than the current pivot_mag. Ties keep the earlier element in row-major order.
- All off-diagonal elements zero -> pivot_mag=0, p=0, q=1.
- Diagonal and lower-triangle values are stored but never affect the pivot.
- matrix_out is not cleared at start of a load. Each entry is overwritten when its data returns.

## Timing
- Reset value of every output is 0:
  - bram_en, bram_addr, matrix_out (all entries), matrix_valid, pivot_p, pivot_q, pivot_mag, busy
  - FSM goes to IDLE and all pipeline valid bits are cleared.
- rst mid-operation aborts the load. BRAM data still in flight is discarded. The next load needs a fresh start.
- Cycle numbering: start is sampled in IDLE at cycle 0. With R reads:
  - addresses are issued in cycles 1..R
  - the last capture happens at cycle R+BRAM_LATENCY
  - matrix_valid rises in cycle R+BRAM_LATENCY+1
- Handshake: the Jacobi unit samples data on the matrix_valid & matrix_ready cycle. matrix_valid falls the next cycle. The earliest next bram_en is 2 cycles after the handshake.
- Back-pressure: matrix_ready may stay low indefinitely. Outputs stay frozen while it is low.

## Configuration
- SYMMETRIC_FOLD_EN defined:
  - only the upper triangle (j >= i) is read, so R = N(N+1)/2, in row-major order over (i, j>=i)
  - each captured off-diagonal value is written to both [i][j] and [j][i]
- SYMMETRIC_FOLD_EN undefined:
  - all R = N*N addresses are read and each value is stored only at its own position
  - asymmetric BRAM contents are passed through unchanged
- The pivot rule is identical in both builds.

## Test plan
- N=4, latency 1, no fold, BRAM[k]=k:
  - matrix_out[k]=k
  - pivot (2,3) with mag 11
  - matrix_valid at cycle 18 after start
- Negative extreme: BRAM[1]=0x80000000 and all other entries 0 -> pivot (0,1), mag 0x80000000.
- Tie: a[0][2]=a[1][3]=-7 and all other off-diagonals 3 -> pivot (0,2), mag 7.
- SYMMETRIC_FOLD_EN, BRAM_LATENCY=3, N=4:
  - exactly 10 bram_en cycles, addresses 0,1,2,3,5,6,7,10,11,15
  - lower triangle mirrors the upper triangle
  - matrix_valid at cycle 14
- Hold matrix_ready=0 for 20 cycles in VALID -> outputs stable; start pulses ignored; exactly one handshake once ready rises.
- Assert rst during READ at cycle 5:
  - all outputs read 0 next cycle
  - late BRAM data does not alter matrix_out
  - a new start completes a correct load

Source files
------------

// File: rtl/cov_matrix_loader.sv
// Reads the NxN covariance matrix out of BRAM into registers while tracking the largest off-diagonal pivot.
// Build option: define SYMMETRIC_FOLD_EN to read only the upper triangle and mirror it into the lower one.
module cov_matrix_loader #(
  parameter int MATRIX_SIZE  = 4,
  parameter int ELEM_WIDTH   = 32,
  parameter int BRAM_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(MATRIX_SIZE*MATRIX_SIZE)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  output logic                                                 bram_en,
  output logic [ADDR_WIDTH-1:0]                                bram_addr,
  input  logic [ELEM_WIDTH-1:0]                                bram_dout,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][ELEM_WIDTH-1:0]   matrix_out,
  output logic                                                 matrix_valid,
  input  logic                                                 matrix_ready,
  output logic [$clog2(MATRIX_SIZE)-1:0]                       pivot_p,
  output logic [$clog2(MATRIX_SIZE)-1:0]                       pivot_q,
  output logic [ELEM_WIDTH-1:0]                                pivot_mag,
  output logic                                                 busy
);

  localparam int IDX_W   = $clog2(MATRIX_SIZE);
  localparam int DRAIN_W = $clog2(BRAM_LATENCY + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(MATRIX_SIZE - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(BRAM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t               state_r, state_nx_s;
  logic [IDX_W-1:0]     row_r, col_r, row_nx_s, col_nx_s;
  logic [ADDR_WIDTH-1:0] addr_nx_s;
  logic [DRAIN_W-1:0]   drain_cnt_r, drain_cnt_nx_s;
  logic                 en_nx_s, valid_nx_s, busy_nx_s, pivot_clear_s;
  logic                 last_s, drain_done_s;

  logic [BRAM_LATENCY-1:0] pipe_vld_r;
  logic [IDX_W-1:0]        pipe_row_r [BRAM_LATENCY];
  logic [IDX_W-1:0]        pipe_col_r [BRAM_LATENCY];

  logic                  cap_vld_s;
  logic [IDX_W-1:0]      cap_row_s, cap_col_s;
  logic [ELEM_WIDTH-1:0] cap_mag_s;
  logic [ADDR_WIDTH-1:0] cap_idx_s;

  // |x| in unsigned arithmetic; the most negative value maps onto 2^(W-1) unchanged.
  function automatic logic [ELEM_WIDTH-1:0] abs_mag(input logic [ELEM_WIDTH-1:0] x);
    if (x[ELEM_WIDTH-1]) abs_mag = ~x + ELEM_WIDTH'(1);
    else                 abs_mag = x;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] flat_idx(input logic [IDX_W-1:0] r,
                                                     input logic [IDX_W-1:0] c);
    flat_idx = ADDR_WIDTH'(r) * ADDR_WIDTH'(MATRIX_SIZE) + ADDR_WIDTH'(c);
  endfunction

  assign last_s       = (row_r == LAST_IDX) && (col_r == LAST_IDX);
  assign drain_done_s = (drain_cnt_r == DRAIN_LAST);
  assign cap_vld_s    = pipe_vld_r[BRAM_LATENCY-1];
  assign cap_row_s    = pipe_row_r[BRAM_LATENCY-1];
  assign cap_col_s    = pipe_col_r[BRAM_LATENCY-1];
  assign cap_mag_s    = abs_mag(bram_dout);
  assign cap_idx_s    = flat_idx(cap_row_s, cap_col_s);

  // State and control register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      bram_en      <= 1'b0;
      bram_addr    <= '0;
      row_r        <= '0;
      col_r        <= '0;
      drain_cnt_r  <= '0;
      matrix_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      bram_en      <= en_nx_s;
      bram_addr    <= addr_nx_s;
      row_r        <= row_nx_s;
      col_r        <= col_nx_s;
      drain_cnt_r  <= drain_cnt_nx_s;
      matrix_valid <= valid_nx_s;
      busy         <= busy_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start)        state_nx_s = READ;  else state_nx_s = IDLE;
      READ:    if (last_s)       state_nx_s = DRAIN; else state_nx_s = READ;
      DRAIN:   if (drain_done_s) state_nx_s = VALID; else state_nx_s = DRAIN;
      VALID:   if (matrix_ready) state_nx_s = IDLE;  else state_nx_s = VALID;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and read walker
  always_comb begin
    en_nx_s        = 1'b0;
    addr_nx_s      = bram_addr;
    row_nx_s       = row_r;
    col_nx_s       = col_r;
    drain_cnt_nx_s = drain_cnt_r;
    valid_nx_s     = 1'b0;
    pivot_clear_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          en_nx_s       = 1'b1;
          addr_nx_s     = '0;
          row_nx_s      = '0;
          col_nx_s      = '0;
          pivot_clear_s = 1'b1;
        end else begin
          en_nx_s = 1'b0;
        end
      end
      READ: begin
        if (last_s) begin
          en_nx_s        = 1'b0;
          drain_cnt_nx_s = '0;
        end else if (col_r == LAST_IDX) begin
          en_nx_s  = 1'b1;
          row_nx_s = row_r + IDX_W'(1);
`ifdef SYMMETRIC_FOLD_EN
          // next row restarts on its diagonal, skipping row_r+1 lower-triangle words
          col_nx_s  = row_r + IDX_W'(1);
          addr_nx_s = bram_addr + ADDR_WIDTH'(row_r) + ADDR_WIDTH'(2);
`else
          col_nx_s  = '0;
          addr_nx_s = bram_addr + ADDR_WIDTH'(1);
`endif
        end else begin
          en_nx_s   = 1'b1;
          col_nx_s  = col_r + IDX_W'(1);
          addr_nx_s = bram_addr + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_done_s) valid_nx_s = 1'b1;
        else              drain_cnt_nx_s = drain_cnt_r + DRAIN_W'(1);
      end
      VALID: begin
        if (matrix_ready) valid_nx_s = 1'b0;
        else              valid_nx_s = 1'b1;
      end
      default: valid_nx_s = 1'b0;
    endcase
    busy_nx_s = (state_nx_s == READ) || (state_nx_s == DRAIN);
  end

  // Read pipeline: tags each issued address with its (row, col) until the data returns
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) begin
        pipe_row_r[k] <= '0;
        pipe_col_r[k] <= '0;
      end
    end else begin
      for (int k = BRAM_LATENCY - 1; k > 0; k--) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_row_r[k] <= pipe_row_r[k-1];
        pipe_col_r[k] <= pipe_col_r[k-1];
      end
      pipe_vld_r[0] <= bram_en;
      pipe_row_r[0] <= row_r;
      pipe_col_r[0] <= col_r;
    end
  end

  // Matrix capture and pivot tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_out <= '0;
      pivot_mag  <= '0;
      pivot_p    <= '0;
      pivot_q    <= '0;
    end else begin
      if (pivot_clear_s) begin
        pivot_mag <= '0;
        pivot_p   <= '0;
        pivot_q   <= IDX_W'(1);
      end else if (cap_vld_s && (cap_col_s > cap_row_s) && (cap_mag_s > pivot_mag)) begin
        pivot_mag <= cap_mag_s;
        pivot_p   <= cap_row_s;
        pivot_q   <= cap_col_s;
      end
      if (cap_vld_s) begin
        matrix_out[cap_idx_s] <= bram_dout;
`ifdef SYMMETRIC_FOLD_EN
        if (cap_col_s != cap_row_s) matrix_out[flat_idx(cap_col_s, cap_row_s)] <= bram_dout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cov_matrix_loader.sv
// Randomized self-checking bench for cov_matrix_loader against a matrix/pivot reference model.
module tb_cov_matrix_loader;
  localparam int N  = 4;
  localparam int W  = 32;
`ifdef SYMMETRIC_FOLD_EN
  localparam int LAT = 3;
  localparam int R   = 10;
  localparam int T_VALID = 14;
`else
  localparam int LAT = 1;
  localparam int R   = 16;
  localparam int T_VALID = 18;
`endif

  logic clk = 1'b0;
  logic rst, start, matrix_ready, bram_en, matrix_valid, busy;
  logic [3:0] bram_addr;
  logic [W-1:0] bram_dout, pivot_mag;
  logic [N*N-1:0][W-1:0] matrix_out;
  logic [1:0] pivot_p, pivot_q;

  int n_cmp = 0;
  int n_bad = 0;

  cov_matrix_loader #(.MATRIX_SIZE(N), .ELEM_WIDTH(W), .BRAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .matrix_out(matrix_out), .matrix_valid(matrix_valid),
    .matrix_ready(matrix_ready), .pivot_p(pivot_p), .pivot_q(pivot_q),
    .pivot_mag(pivot_mag), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model with LAT-cycle read latency; returns junk when not enabled
  logic [W-1:0] mem [N*N];
  logic [W-1:0] dly [LAT];
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) dly[k] <= dly[k-1];
    dly[0] <= bram_en ? mem[bram_addr] : $urandom;
  end
  assign bram_dout = dly[LAT-1];

  // Reference model
  logic [W-1:0] exp_mat [N*N];
  int exp_p, exp_q;
  logic [W-1:0] exp_mag;
  int exp_addr[$];
  int addr_seen[$];
  int busy_cnt, valid_cyc;

  function automatic void build_model();
    longint best, v, mag;
    best = 0; exp_p = 0; exp_q = 1;
    exp_addr.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
`ifdef SYMMETRIC_FOLD_EN
        if (j >= i) begin
          exp_addr.push_back(i*N + j);
          exp_mat[i*N + j] = mem[i*N + j];
          exp_mat[j*N + i] = mem[i*N + j];
        end
`else
        exp_addr.push_back(i*N + j);
        exp_mat[i*N + j] = mem[i*N + j];
`endif
        if (j > i) begin
          v = longint'($signed(mem[i*N + j]));
          mag = (v < 0) ? -v : v;
          if (mag > best) begin best = mag; exp_p = i; exp_q = j; end
        end
      end
    exp_mag = best[W-1:0];
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < N*N; k++) begin
      case ($urandom_range(0, 7))
        0:       mem[k] = 32'h8000_0000;
        1:       mem[k] = -32'($urandom_range(1, 20));
        2:       mem[k] = 32'($urandom_range(0, 20));
        default: mem[k] = $urandom | 32'h1;
      endcase
    end
  endfunction

  task automatic do_load();
    addr_seen.delete(); busy_cnt = 0; valid_cyc = -1;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 200 && valid_cyc < 0; c++) begin
      @(negedge clk); start = 1'b0;
      if (bram_en) addr_seen.push_back(int'(bram_addr));
      if (busy) busy_cnt++;
      if (matrix_valid) valid_cyc = c;
    end
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(negedge clk);
    matrix_ready = 1'b1;
    @(negedge clk); matrix_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bram_en !== 1'b0)      begin n_bad++; $display("FAIL rst_en: got %0h want 0", bram_en); end
    n_cmp++; if (bram_addr !== 4'd0)    begin n_bad++; $display("FAIL rst_addr: got %0h want 0", bram_addr); end
    n_cmp++; if (matrix_out !== '0)     begin n_bad++; $display("FAIL rst_mat: got nonzero want 0"); end
    n_cmp++; if (matrix_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", matrix_valid); end
    n_cmp++; if (pivot_p !== 2'd0)      begin n_bad++; $display("FAIL rst_p: got %0h want 0", pivot_p); end
    n_cmp++; if (pivot_q !== 2'd0)      begin n_bad++; $display("FAIL rst_q: got %0h want 0", pivot_q); end
    n_cmp++; if (pivot_mag !== 32'd0)   begin n_bad++; $display("FAIL rst_mag: got %0h want 0", pivot_mag); end
    n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    bit bad;
    for (int k = 0; k < N*N; k++) mem[k] = 32'(k);
    build_model();
    do_load();
    n_cmp++; if (valid_cyc != T_VALID) begin n_bad++; $display("FAIL ramp_valid_cycle: got %0d want %0d", valid_cyc, T_VALID); end
    n_cmp++; if (addr_seen.size() != R) begin n_bad++; $display("FAIL ramp_en_count: got %0d want %0d", addr_seen.size(), R); end
    bad = (addr_seen.size() != exp_addr.size());
    for (int k = 0; k < addr_seen.size() && !bad; k++) if (addr_seen[k] != exp_addr[k]) bad = 1'b1;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL ramp_addr_seq: got %p want %p", addr_seen, exp_addr); end
    n_cmp++; if (busy_cnt != R + LAT) begin n_bad++; $display("FAIL ramp_busy: got %0d want %0d", busy_cnt, R + LAT); end
    for (int k = 0; k < N*N; k++) begin
      n_cmp++; if (matrix_out[k] !== exp_mat[k]) begin n_bad++; $display("FAIL ramp_mat[%0d]: got %0h want %0h", k, matrix_out[k], exp_mat[k]); end
    end
    n_cmp++; if ({pivot_p, pivot_q, pivot_mag} !== {2'd2, 2'd3, 32'd11})
      begin n_bad++; $display("FAIL ramp_pivot: got (%0d,%0d,%0h) want (2,3,b)", pivot_p, pivot_q, pivot_mag); end
    accept(0);
  endtask

  task automatic test_directed();
    int lp [3] = '{0, 0, 0};
    int lq [3] = '{1, 2, 1};
    logic [W-1:0] lm [3] = '{32'h8000_0000, 32'd7, 32'd0};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          case (t)
            0:       mem[i*N+j] = 32'd0;
            1:       mem[i*N+j] = (i == j) ? $urandom : 32'd3;
            default: mem[i*N+j] = (j > i) ? 32'd0 : ($urandom | 32'h1);
          endcase
        end
      if (t == 0) mem[1] = 32'h8000_0000;
      if (t == 1) begin mem[2] = 32'hFFFF_FFF9; mem[7] = 32'hFFFF_FFF9; end
      build_model();
      do_load();
      n_cmp++; if (valid_cyc != T_VALID) begin n_bad++; $display("FAIL dir%0d_valid_cycle: got %0d want %0d", t, valid_cyc, T_VALID); end
      n_cmp++; if ({pivot_p, pivot_q, pivot_mag} !== {2'(lp[t]), 2'(lq[t]), lm[t]})
        begin n_bad++; $display("FAIL dir%0d_pivot: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", t, pivot_p, pivot_q, pivot_mag, lp[t], lq[t], lm[t]); end
      for (int k = 0; k < N*N; k++) begin
        n_cmp++; if (matrix_out[k] !== exp_mat[k]) begin n_bad++; $display("FAIL dir%0d_mat[%0d]: got %0h want %0h", t, k, matrix_out[k], exp_mat[k]); end
      end
      accept($urandom_range(0, 2));
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      fill_random();
      build_model();
      do_load();
      n_cmp++; if (valid_cyc != R + LAT + 1) begin n_bad++; $display("FAIL rnd%0d_valid_cycle: got %0d want %0d", t, valid_cyc, R + LAT + 1); end
      n_cmp++; if ({pivot_p, pivot_q, pivot_mag} !== {2'(exp_p), 2'(exp_q), exp_mag})
        begin n_bad++; $display("FAIL rnd%0d_pivot: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", t, pivot_p, pivot_q, pivot_mag, exp_p, exp_q, exp_mag); end
      for (int k = 0; k < N*N; k++) begin
        n_cmp++; if (matrix_out[k] !== exp_mat[k]) begin n_bad++; $display("FAIL rnd%0d_mat[%0d]: got %0h want %0h", t, k, matrix_out[k], exp_mat[k]); end
      end
      accept($urandom_range(0, 3));
    end
  endtask

  task automatic test_backpressure();
    logic [N*N-1:0][W-1:0] snap_mat;
    logic [W-1:0] snap_mag;
    logic [1:0] snap_p, snap_q;
    fill_random();
    build_model();
    do_load();
    snap_mat = matrix_out; snap_mag = pivot_mag; snap_p = pivot_p; snap_q = pivot_q;
    n_cmp++; if ({snap_p, snap_q, snap_mag} !== {2'(exp_p), 2'(exp_q), exp_mag})
      begin n_bad++; $display("FAIL bp_pivot: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", snap_p, snap_q, snap_mag, exp_p, exp_q, exp_mag); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (matrix_out !== snap_mat || {pivot_p, pivot_q, pivot_mag} !== {snap_p, snap_q, snap_mag} ||
          matrix_valid !== 1'b1 || bram_en !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got valid=%0b en=%0b busy=%0b pivot=(%0d,%0d,%0h) want frozen", i, matrix_valid, bram_en, busy, pivot_p, pivot_q, pivot_mag);
      end
      start = (i % 4 == 0) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    matrix_ready = 1'b1;
    @(negedge clk);
    matrix_ready = 1'b0;
    n_cmp++; if (matrix_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid=%0b want 0", matrix_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (matrix_valid !== 1'b0 || bram_en !== 1'b0)
        begin n_bad++; $display("FAIL bp_after[%0d]: got valid=%0b en=%0b want 0,0", i, matrix_valid, bram_en); end
    end
  endtask

  task automatic test_back_to_back();
    int vc;
    fill_random();
    do_load();
    fill_random();
    build_model();
    matrix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    matrix_ready = 1'b0;
    n_cmp++; if (matrix_valid !== 1'b0 || bram_en !== 1'b0)
      begin n_bad++; $display("FAIL b2b_gap: got valid=%0b en=%0b want 0,0", matrix_valid, bram_en); end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (bram_en !== 1'b1 || bram_addr !== 4'd0)
      begin n_bad++; $display("FAIL b2b_first_read: got en=%0b addr=%0d want 1,0", bram_en, bram_addr); end
    vc = -1;
    for (int c = 2; c <= 200 && vc < 0; c++) begin
      @(negedge clk);
      if (matrix_valid) vc = c;
    end
    n_cmp++; if (vc != R + LAT + 1) begin n_bad++; $display("FAIL b2b_valid_cycle: got %0d want %0d", vc, R + LAT + 1); end
    for (int k = 0; k < N*N; k++) begin
      n_cmp++; if (matrix_out[k] !== exp_mat[k]) begin n_bad++; $display("FAIL b2b_mat[%0d]: got %0h want %0h", k, matrix_out[k], exp_mat[k]); end
    end
    accept(0);
  endtask

  task automatic test_reset_mid();
    fill_random();
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 5; c++) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({bram_en, bram_addr, matrix_valid, pivot_p, pivot_q, pivot_mag, busy} !== '0 || matrix_out !== '0)
      begin n_bad++; $display("FAIL midrst_outputs: got en=%0b addr=%0d valid=%0b mag=%0h busy=%0b want all 0", bram_en, bram_addr, matrix_valid, pivot_mag, busy); end
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      n_cmp++; if (matrix_out !== '0 || bram_en !== 1'b0 || matrix_valid !== 1'b0 || busy !== 1'b0)
        begin n_bad++; $display("FAIL midrst_late[%0d]: got en=%0b valid=%0b busy=%0b mat_zero=%0b want idle and cleared", i, bram_en, matrix_valid, busy, matrix_out == '0); end
    end
    build_model();
    do_load();
    n_cmp++; if (valid_cyc != R + LAT + 1) begin n_bad++; $display("FAIL midrst_valid_cycle: got %0d want %0d", valid_cyc, R + LAT + 1); end
    n_cmp++; if ({pivot_p, pivot_q, pivot_mag} !== {2'(exp_p), 2'(exp_q), exp_mag})
      begin n_bad++; $display("FAIL midrst_pivot: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", pivot_p, pivot_q, pivot_mag, exp_p, exp_q, exp_mag); end
    for (int k = 0; k < N*N; k++) begin
      n_cmp++; if (matrix_out[k] !== exp_mat[k]) begin n_bad++; $display("FAIL midrst_mat[%0d]: got %0h want %0h", k, matrix_out[k], exp_mat[k]); end
    end
    accept(1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
